// File: rtl/stage_memory.sv
`default_nettype none
// ============================================================================
// Module   : stage_memory
// Purpose  : RISC-V memory stage: req/ack loads/stores, branch redirect, WB reg
// Revision : 1.0
// ============================================================================
module stage_memory (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_data0,
  input  logic [31:0] mem_data1,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_extend,
  input  logic [1:0]  mem_width,
  input  logic        mem_jmp,
  input  logic        mem_br,
  input  logic        mem_br_inv,
  input  logic [4:0]  wb_reg,
  output logic        mem_stall,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_reg_r,
  output logic [31:0] wb_data,
  output logic        mem_misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_rdata;

  logic        w_access;
  logic        w_misal;
  logic        w_misal_access;
  logic        w_complete;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;

  assign w_off          = mem_data0[1:0];
  assign w_access       = mem_valid & (mem_read | mem_write);
  assign w_misal_access = w_access & w_misal;

  always_comb begin
    w_misal     = 1'b0;
    w_be        = 4'b1111;
    w_wdata     = mem_data1;
    w_load_data = w_shifted;
    case (mem_width)
      2'd0: begin
        w_be        = 4'b0001 << w_off;
        w_wdata     = {4{mem_data1[7:0]}};
        w_load_data = mem_extend ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                 : {24'd0, w_shifted[7:0]};
      end
      2'd1: begin
        w_misal     = mem_data0[0];
        w_be        = 4'b0011 << w_off;
        w_wdata     = {2{mem_data1[15:0]}};
        w_load_data = mem_extend ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                 : {16'd0, w_shifted[15:0]};
      end
      default: begin
        w_misal = |mem_data0[1:0];
      end
    endcase
  end

  // Execute holds the instruction through DONE, so the lane offset is still valid here.
  assign w_shifted  = r_rdata >> {w_off, 3'b000};

  assign mem_stall  = w_access & ~w_misal & (r_state != DONE);
  assign w_complete = mem_valid & ~mem_stall;
  assign br_taken   = w_complete & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
  assign br_target  = {mem_data1[31:1], 1'b0};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_rdata        <= 32'd0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'd0;
      dmem_be        <= 4'd0;
      dmem_wdata     <= 32'd0;
      wb_valid       <= 1'b0;
      wb_pc          <= 32'd0;
      wb_reg_r       <= 5'd0;
      wb_data        <= 32'd0;
      mem_misaligned <= 1'b0;
    end else begin
      mem_misaligned <= w_misal_access;
      wb_valid       <= w_complete & ~w_misal_access;
      if (w_complete) begin
        wb_pc    <= mem_pc;
        wb_reg_r <= wb_reg;
        wb_data  <= (w_access & mem_read) ? w_load_data : mem_data0;
      end
      case (r_state)
        IDLE: begin
          if (w_access & ~w_misal) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {mem_data0[31:2], 2'b00};
            dmem_be    <= w_be;
            dmem_wdata <= w_wdata;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            r_rdata  <= dmem_rdata;
            r_state  <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Memory stage of the 5-stage RISC-V pipeline. It consumes the execute-stage output register (mem_* bundle) and performs loads and stores over a req/ack data-memory bus.
- It resolves jumps and branches into a fetch redirect.
- It registers the result into the writeback stage.
- It is the sole source of mem_stall back to execute.

Parameters:
- None.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- mem_valid  in  1  execute output valid; held high by execute while mem_stall
- mem_pc  in  32  instruction PC
- mem_data0  in  32  ALU result: load/store address, branch compare result (bit 0), or link value pc+4
- mem_data1  in  32  store data, or jump/branch target
- mem_read  in  1  load
- mem_write  in  1  store
- mem_extend  in  1  load sign-extend (1) / zero-extend (0)
- mem_width  in  2  0=byte 1=half 2=word; 3 treated as word
- mem_jmp  in  1  unconditional jump
- mem_br  in  1  conditional branch
- mem_br_inv  in  1  invert branch condition
- wb_reg  in  5  destination register
- mem_stall  out  1  hold execute outputs
- br_taken  out  1  redirect fetch and flush younger stages (combinational)
- br_target  out  32  redirect address
- dmem_req  out  1  bus request (registered)
- dmem_we  out  1  write enable (registered)
- dmem_addr  out  32  word-aligned address, low 2 bits 0 (registered)
- dmem_be  out  4  byte enables (registered)
- dmem_wdata  out  32  lane-shifted store data (registered)
- dmem_ack  in  1  bus completion; rdata valid this cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  writeback valid (registered)
- wb_pc  out  32  PC of the retired instruction
- wb_reg_r  out  5  destination register
- wb_data  out  32  writeback data
- mem_misaligned  out  1  one-cycle trap pulse (registered)

Behaviour:
- Definitions:
  - access = mem_valid & (mem_read | mem_write).
  - misal = (width==1 & addr[0]) | (width>=2 & addr[1:0]!=0), where addr = mem_data0.
- FSM states IDLE, BUSY, DONE; reset state is IDLE.
- IDLE:
  - If access & ~misal: load dmem_req=1, dmem_we=mem_write, dmem_addr={addr[31:2],2'b00}, be, and wdata; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - All dmem_* outputs hold stable.
  - On dmem_ack: dmem_req<=0, latch dmem_rdata, go to DONE.
- DONE: unconditionally return to IDLE.
- dmem_ack is ignored outside BUSY.
- mem_stall = access & ~misal & (state != DONE), combinational. Minimum load/store occupancy is 3 cycles: IDLE, BUSY with ack, DONE.
- Non-access instructions and misaligned accesses complete in one cycle with no stall.
- Byte enables:
  - byte: 1 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data: wdata = mem_data1 replicated into lanes (byte: {4{d[7:0]}}; half: {2{d[15:0]}}; word: d).
- Load data:
  - Shift the latched word right by 8*addr[1:0].
  - Take 8, 16, or 32 bits per width.
  - Sign- or zero-extend per mem_extend.
- Branch resolution, valid only when the instruction completes (mem_valid & ~mem_stall):
  - br_taken = mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)).
  - br_target = {mem_data1[31:1],1'b0}.
  - br_taken is 0 otherwise.
- Writeback register, updated every cycle:
  - wb_valid <= mem_valid & ~mem_stall & ~misal_access.
  - wb_pc, wb_reg_r, and wb_data update only when completing.
  - wb_data = extended load data for loads, else mem_data0. For jumps mem_data0 is pc+4.
- mem_misaligned <= access & misal, a one-cycle pulse. The faulting instruction produces no bus traffic and no writeback.
- Reset values: mem_misaligned, wb_valid, dmem_req, and dmem_we are 0; all other registered outputs are 0.
- Reset mid-transaction: the FSM returns to IDLE and dmem_req drops the next cycle. A late ack is ignored.

Test Plan:
- Load word, addr 0x100, ack on the 2nd BUSY cycle, rdata 0xDEADBEEF:
  - dmem_req 1 for 2 cycles, be=1111.
  - mem_stall high 3 cycles.
  - wb_valid 1 with wb_data=0xDEADBEEF.
- Load byte signed, addr 0x103, rdata 0x80xxxxxx -> wb_data=0xFFFFFF80.
- Same load unsigned half at addr 0x102, rdata 0xABCD0000 -> wb_data=0x0000ABCD.
- Store half, addr 0x206, data1=0x12345678 -> dmem_addr=0x204, be=1100, wdata=0x56785678, we=1, wb_valid=1.
- Branch: br=1, data0[0]=0, br_inv=1, data1=0x401 -> br_taken=1, br_target=0x400, no stall.
- Same branch with br_inv=0 -> br_taken=0.
- Misaligned word load at 0x102 -> dmem_req stays 0, mem_misaligned pulses once, wb_valid=0, no stall.
- Reset asserted while in BUSY -> dmem_req=0 and state IDLE next cycle; a subsequent ack has no effect.
